dcache_controller: RTL
======================

// Module: dcache_controller
// PURPOSE
//   Direct-mapped, write-back, write-allocate L1 data cache between the MEM stage and the
//   external data memory. It produces cpu_stall_i for every pipeline register (IF_ID,
//   ID_EX, EX_MEM, MEM_WB), so a miss freezes the whole pipeline until the fill completes.
//   Hits return data combinationally. Misses run a memory handshake that takes several cycles.
// PARAMETERS
//   ADDR_W     32   byte address width
//   LINE_W     256  cache line width in bits (32 B); must equal the memory data width
//   NUM_SETS   16   number of lines; index = log2(NUM_SETS) bits
//   OFFSET_W and INDEX_W are derived as localparams. TAG_W = ADDR_W - INDEX_W - OFFSET_W.
// PORTS
//   clk_i            in   1       clock
//   rst_i            in   1       synchronous, active-high reset
//   cpu_addr_i       in   ADDR_W  byte address, word aligned
//   cpu_data_i       in   32      store data
//   cpu_MemRead_i    in   1       load request
//   cpu_MemWrite_i   in   1       store request (never high together with cpu_MemRead_i)
//   cpu_data_o       out  32      load data; valid when the request is high and cpu_stall_o is 0
//   cpu_stall_o      out  1       pipeline freeze
//   mem_addr_o       out  ADDR_W  line-aligned memory address
//   mem_data_o       out  LINE_W  write-back line
//   mem_enable_o     out  1       memory request
//   mem_write_o      out  1       1 = write line, 0 = read line
//   mem_data_i       in   LINE_W  fill line; valid only while mem_ack_i is high
//   mem_ack_i        in   1       1-cycle completion pulse
// BEHAVIOUR
//   Storage per set: valid, dirty, tag[TAG_W], line[LINE_W].
//   hit = req & valid[idx] & (tag[idx] == addr tag), where req = MemRead | MemWrite.
//   Reset (sync): all valid/dirty = 0; state = IDLE; mem_enable_o = mem_write_o = 0;
//     mem_addr_o = 0; mem_data_o = 0; cpu_data_o = 0.
//   cpu_stall_o = req & ~(state == IDLE & hit). It is combinational, with no stall when there is no request.
//   Read hit: cpu_data_o = word addr[OFFSET_W-1:2] of the line, same cycle, zero latency.
//   Write hit: at the clock edge, merge cpu_data_i into the selected word and set dirty = 1.
//     Memory is untouched.
//   FSM:
//     IDLE       req & ~hit -> MISS. Otherwise stay.
//     MISS       victim dirty -> WRITEBACK. Otherwise -> READMISS.
//     WRITEBACK  mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, idx, 0},
//                mem_data_o = victim line. On mem_ack_i -> READMISS.
//     READMISS   mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {req tag, idx, 0}.
//                On mem_ack_i: line <= mem_data_i, tag <= req tag, valid = 1, dirty = 0;
//                next state is READMISSOK.
//     READMISSOK 1 cycle, stall held -> IDLE. The request now hits and completes in IDLE.
//   Handshake: mem_enable_o and mem_addr_o/mem_data_o stay stable from entry into the state
//     until the cycle mem_ack_i is high. They drop the cycle after. Ack seen in any other state is ignored.
//   Latency: if ack arrives on the Nth enable cycle, a clean miss stalls N+3 cycles.
//     A dirty miss stalls Nwb+Nrd+3 cycles.
//   The address and request are held stable by the frozen pipeline for the whole miss.
//     The controller does not latch them.
//   Reset mid-operation wins over everything: any in-flight transaction is abandoned,
//     enable drops on the next edge, and all lines are invalidated.
// STRUCTURE
//   The shared package holds the state encoding (IDLE, MISS, WRITEBACK, READMISS, READMISSOK)
//   and the default widths.
//   One sub-module, dcache_sram, holds the valid/dirty/tag/data arrays. It has
//   a combinational read, a synchronous write with full-line or word-enable, and a sync clear on rst_i.
// TESTING
//   1 Clean read miss at 0x0000_0400, ack on the 3rd enable cycle
//     -> mem_addr_o = 0x400, stall for 6 cycles, then the correct word is returned with stall 0.
//   2 Load 0x404 right after test 1 -> hit, stall 0, no mem_enable_o.
//   3 Store 0xDEADBEEF to 0x408 (hit) -> no memory traffic; a reload of 0x408 returns 0xDEADBEEF.
//   4 Load 0x0000_0600 (same idx 0, new tag) after test 3
//     -> WRITEBACK to 0x400 with the line containing 0xDEADBEEF, then READMISS from 0x600.
//   5 Assert rst_i during READMISS -> next edge gives enable 0 and state IDLE.
//     A reload of 0x400 then misses.
//   6 Hold mem_ack_i low for 20 cycles -> enable, address and stall stay stable throughout.
//     A spurious ack in IDLE is ignored.

Source files
------------

// File: rtl/dcache_controller_pkg.sv
// Shared types and default geometry
// for the L1 data cache controller.
package dcache_controller_pkg;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_LINE_W   = 256;
  localparam int DEF_NUM_SETS = 16;

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WRITEBACK,
    READMISS,
    READMISSOK
  } state_t;

endpackage

// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side bundles
// of the L1 data cache controller.
interface dcache_cpu_if
  import dcache_controller_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [31:0]       cpu_data_i;
  logic              cpu_MemRead_i;
  logic              cpu_MemWrite_i;
  logic [31:0]       cpu_data_o;
  logic              cpu_stall_o;

  modport master (
    output cpu_addr_i,
    output cpu_data_i,
    output cpu_MemRead_i,
    output cpu_MemWrite_i,
    input  cpu_data_o,
    input  cpu_stall_o
  );

  modport slave (
    input  cpu_addr_i,
    input  cpu_data_i,
    input  cpu_MemRead_i,
    input  cpu_MemWrite_i,
    output cpu_data_o,
    output cpu_stall_o
  );
endinterface

interface dcache_mem_if
  import dcache_controller_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
);
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;

  modport master (
    output mem_addr_o,
    output mem_data_o,
    output mem_enable_o,
    output mem_write_o,
    input  mem_data_i,
    input  mem_ack_i
  );

  modport slave (
    input  mem_addr_o,
    input  mem_data_o,
    input  mem_enable_o,
    input  mem_write_o,
    output mem_data_i,
    output mem_ack_i
  );
endinterface

// File: rtl/dcache_controller_sram.sv
// Valid/dirty/tag/data arrays with
// combinational read and sync write.
module dcache_sram #(
  parameter int TAG_W   = 23,
  parameter int INDEX_W = 4,
  parameter int LINE_W  = 256,
  parameter int WORD_W  = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] idx,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_line,
  input  logic               fill_en,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [LINE_W-1:0]  fill_line,
  input  logic               word_en,
  input  logic [WORD_W-1:0]  word_sel,
  input  logic [31:0]        word_data
);

  localparam int SETS = 1 << INDEX_W;

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] line_q [SETS];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = line_q[idx];

  // status bits: cleared by reset, set by fill or store
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_en) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // tag and line payload: whole-line fill or single-word merge
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tag_q[idx]  <= fill_tag;
      line_q[idx] <= fill_line;
    end else if (word_en) begin
      line_q[idx][{word_sel, 5'd0} +: 32] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back L1 data cache
// controller; freezes the pipeline on a miss.
module dcache_controller
  import dcache_controller_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LINE_W   = DEF_LINE_W,
  parameter int NUM_SETS = DEF_NUM_SETS
) (
  input logic         clk_i,
  input logic         rst_i,
  dcache_cpu_if.slave cpu,
  dcache_mem_if.master mem
);

  localparam int OFFSET_W = $clog2(LINE_W / 8);
  localparam int INDEX_W  = $clog2(NUM_SETS);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WORD_W   = OFFSET_W - 2;

  state_t state;
  state_t state_nx;

  logic [TAG_W-1:0]   tag;
  logic [INDEX_W-1:0] idx;
  logic [WORD_W-1:0]  word;
  logic               req;
  logic               hit;
  logic               vvalid;
  logic               vdirty;
  logic [TAG_W-1:0]   vtag;
  logic [LINE_W-1:0]  vline;
  logic               fill_en;
  logic               word_en;
  logic               en;
  logic               wr;
  logic [ADDR_W-1:0]  addr;
  logic [LINE_W-1:0]  data;
  logic               addr_unused;

  assign tag  = cpu.cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign idx  = cpu.cpu_addr_i[OFFSET_W +: INDEX_W];
  assign word = cpu.cpu_addr_i[2 +: WORD_W];
  assign addr_unused = ^cpu.cpu_addr_i[1:0];

  assign req = cpu.cpu_MemRead_i | cpu.cpu_MemWrite_i;
  assign hit = req & vvalid & (vtag == tag);

  assign cpu.cpu_stall_o = req & ~((state == IDLE) & hit);
  assign cpu.cpu_data_o  = hit ? vline[{word, 5'd0} +: 32] : 32'd0;

  assign word_en = (state == IDLE) & hit & cpu.cpu_MemWrite_i;

  assign mem.mem_enable_o = en;
  assign mem.mem_write_o  = wr;
  assign mem.mem_addr_o   = addr;
  assign mem.mem_data_o   = data;

  dcache_sram #(
    .TAG_W   (TAG_W),
    .INDEX_W (INDEX_W),
    .LINE_W  (LINE_W),
    .WORD_W  (WORD_W)
  ) u_sram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .idx       (idx),
    .rd_valid  (vvalid),
    .rd_dirty  (vdirty),
    .rd_tag    (vtag),
    .rd_line   (vline),
    .fill_en   (fill_en),
    .fill_tag  (tag),
    .fill_line (mem.mem_data_i),
    .word_en   (word_en),
    .word_sel  (word),
    .word_data (cpu.cpu_data_i)
  );

  // miss FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  // next state and memory handshake outputs
  always_comb begin
    state_nx = state;
    en       = 1'b0;
    wr       = 1'b0;
    addr     = '0;
    data     = '0;
    fill_en  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req & ~hit) state_nx = MISS;
      end
      MISS: begin
        if (vvalid & vdirty) state_nx = WRITEBACK;
        else                 state_nx = READMISS;
      end
      WRITEBACK: begin
        en   = 1'b1;
        wr   = 1'b1;
        addr = {vtag, idx, {OFFSET_W{1'b0}}};
        data = vline;
        if (mem.mem_ack_i) state_nx = READMISS;
      end
      READMISS: begin
        en   = 1'b1;
        addr = {tag, idx, {OFFSET_W{1'b0}}};
        if (mem.mem_ack_i) begin
          fill_en  = 1'b1;
          state_nx = READMISSOK;
        end
      end
      READMISSOK: state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

endmodule
